// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: occupancy controller for a single-gate parking lot.
//
// Two photo-sensors (outer A, inner B) are synchronised, debounced as a pair and
// fed to a direction-decoding FSM. A completed entry or exit adjusts a saturating
// occupancy count; attempts past the limits raise overflow/underflow pulses.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   RSTN         in   asynchronous active-low reset
//   sensA        in   outer sensor, 1 = beam blocked (asynchronous)
//   sensB        in   inner sensor, 1 = beam blocked (asynchronous)
//   cntNum[4:0]  out  current occupancy 0..CAP
//   full         out  cntNum == CAP
//   empty        out  cntNum == 0
//   enter_pulse  out  one-cycle pulse on a counted entry
//   exit_pulse   out  one-cycle pulse on a counted exit
//   ovf_pulse    out  one-cycle pulse on an entry while full
//   udf_pulse    out  one-cycle pulse on an exit while empty
module parking_lot_ctrl #(
    parameter int unsigned CAP        = 25,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       CLOCK_50,
    input  logic       RSTN,
    input  logic       sensA,
    input  logic       sensB,
    output logic [4:0] cntNum,
    output logic       full,
    output logic       empty,
    output logic       enter_pulse,
    output logic       exit_pulse,
    output logic       ovf_pulse,
    output logic       udf_pulse
);

    localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES);
    localparam logic [4:0] CapVal = 5'(CAP);

    typedef enum logic [2:0] {
        StIdle,
        StEn1,
        StEn2,
        StEn3,
        StEx1,
        StEx2,
        StEx3
    } state_e;

    // Synchroniser and debounce state
    logic            a_meta_q, a_sync_q, b_meta_q, b_sync_q;
    logic [1:0]      sync_pair;
    logic [1:0]      cand_q, cand_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      pair_q, pair_d;

    // FSM and counter state
    state_e     state_q, state_d;
    logic       commit_in, commit_out;
    logic [4:0] cnt_q, cnt_d;
    logic       full_q, full_d, empty_q, empty_d;
    logic       enter_q, enter_d, exit_q, exit_d, ovf_q, ovf_d, udf_q, udf_d;

    assign sync_pair = {a_sync_q, b_sync_q};

    always_ff @(posedge CLOCK_50 or negedge RSTN) begin
        if (!RSTN) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
        end else begin
            a_meta_q <= sensA;
            a_sync_q <= a_meta_q;
            b_meta_q <= sensB;
            b_sync_q <= b_meta_q;
        end
    end

    // deb_cnt_d is the number of consecutive samples (including this one) for which
    // the synced pair has equalled cand; the pair is accepted once that reaches DEB_CYCLES.
    always_comb begin
        cand_d = sync_pair;
        if (sync_pair != cand_q) begin
            deb_cnt_d = DebW'(1);
        end else if (deb_cnt_q == DebMax) begin
            deb_cnt_d = deb_cnt_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
        end
        pair_d = pair_q;
        if (deb_cnt_d == DebMax) begin
            pair_d = sync_pair;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN) begin
        if (!RSTN) begin
            cand_q    <= 2'b00;
            deb_cnt_q <= '0;
            pair_q    <= 2'b00;
        end else begin
            cand_q    <= cand_d;
            deb_cnt_q <= deb_cnt_d;
            pair_q    <= pair_d;
        end
    end

    // Direction decoder; pair_q is {A, B}
    always_comb begin
        state_d    = state_q;
        commit_in  = 1'b0;
        commit_out = 1'b0;
        case (state_q)
            StIdle: begin
                if (pair_q == 2'b10) state_d = StEn1;
                else if (pair_q == 2'b01) state_d = StEx1;
            end
            StEn1: begin
                if (pair_q == 2'b11) state_d = StEn2;
                else if (pair_q == 2'b00 || pair_q == 2'b01) state_d = StIdle;
            end
            StEn2: begin
                if (pair_q == 2'b01) state_d = StEn3;
                else if (pair_q == 2'b10) state_d = StEn1;
                else if (pair_q == 2'b00) state_d = StIdle;
            end
            StEn3: begin
                if (pair_q == 2'b00) begin
                    state_d   = StIdle;
                    commit_in = 1'b1;
                end else if (pair_q == 2'b11) begin
                    state_d = StEn2;
                end else if (pair_q == 2'b10) begin
                    state_d = StIdle;
                end
            end
            StEx1: begin
                if (pair_q == 2'b11) state_d = StEx2;
                else if (pair_q == 2'b00 || pair_q == 2'b10) state_d = StIdle;
            end
            StEx2: begin
                if (pair_q == 2'b10) state_d = StEx3;
                else if (pair_q == 2'b01) state_d = StEx1;
                else if (pair_q == 2'b00) state_d = StIdle;
            end
            StEx3: begin
                if (pair_q == 2'b00) begin
                    state_d    = StIdle;
                    commit_out = 1'b1;
                end else if (pair_q == 2'b11) begin
                    state_d = StEx2;
                end else if (pair_q == 2'b01) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating count; status flags follow the next count so they move with it
    always_comb begin
        cnt_d   = cnt_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (commit_in) begin
            if (cnt_q < CapVal) begin
                cnt_d   = cnt_q + 5'd1;
                enter_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (commit_out) begin
            if (cnt_q != 5'd0) begin
                cnt_d  = cnt_q - 5'd1;
                exit_d = 1'b1;
            end else begin
                udf_d = 1'b1;
            end
        end
        full_d  = (cnt_d == CapVal);
        empty_d = (cnt_d == 5'd0);
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign cntNum      = cnt_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;
    assign ovf_pulse   = ovf_q;
    assign udf_pulse   = udf_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench for parking_lot_ctrl with DEB_CYCLES = 4. Expected pulse
// events are queued as each gate sequence is driven and popped by a monitor
// whenever the DUT raises any pulse.
module tb_parking_lot_ctrl;

    localparam int unsigned CAP = 25;
    localparam int unsigned DEB = 4;

    localparam logic [3:0] EvEnter = 4'b1000;
    localparam logic [3:0] EvExit  = 4'b0100;
    localparam logic [3:0] EvOvf   = 4'b0010;
    localparam logic [3:0] EvUdf   = 4'b0001;

    typedef struct packed {
        logic [3:0] ev;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       RSTN     = 1'b0;
    logic       sensA    = 1'b0;
    logic       sensB    = 1'b0;
    logic [4:0] cntNum;
    logic       full, empty, enter_pulse, exit_pulse, ovf_pulse, udf_pulse;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [3:0] mon_ev;
    int         n_vec     = 0;
    int         n_err     = 0;
    int         model_cnt = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    parking_lot_ctrl #(
        .CAP       (CAP),
        .DEB_CYCLES(DEB)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RSTN       (RSTN),
        .sensA      (sensA),
        .sensB      (sensB),
        .cntNum     (cntNum),
        .full       (full),
        .empty      (empty),
        .enter_pulse(enter_pulse),
        .exit_pulse (exit_pulse),
        .ovf_pulse  (ovf_pulse),
        .udf_pulse  (udf_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
        end
    endtask

    // Every pulse cycle consumes one expected event; a stretched pulse finds an empty queue
    always @(negedge CLOCK_50) begin
        if (RSTN) begin
            mon_ev = {enter_pulse, exit_pulse, ovf_pulse, udf_pulse};
            if (mon_ev != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(mon_ev), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", 32'(mon_ev), 32'(mon_e.ev));
                    check("pulse_cnt", 32'(cntNum), 32'(mon_e.cnt));
                    check("pulse_full", 32'(full), 32'(mon_e.full));
                    check("pulse_empty", 32'(empty), 32'(mon_e.empty));
                end
            end
        end
    end

    task automatic step(input logic [1:0] ab, input int n);
        {sensA, sensB} = ab;
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] ev);
        exp_t e;
        e.ev    = ev;
        e.cnt   = 5'(model_cnt);
        e.full  = (model_cnt == CAP);
        e.empty = (model_cnt == 0);
        exp_q.push_back(e);
    endtask

    task automatic do_entry();
        if (model_cnt < CAP) begin
            model_cnt++;
            push_exp(EvEnter);
        end else begin
            push_exp(EvOvf);
        end
        step(2'b10, 10);
        step(2'b11, 10);
        step(2'b01, 10);
        step(2'b00, 10);
    endtask

    task automatic do_exit();
        if (model_cnt > 0) begin
            model_cnt--;
            push_exp(EvExit);
        end else begin
            push_exp(EvUdf);
        end
        step(2'b01, 10);
        step(2'b11, 10);
        step(2'b10, 10);
        step(2'b00, 10);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cnt"}, 32'(cntNum), 32'(model_cnt));
        check({tag, "_full"}, 32'(full), 32'(model_cnt == CAP));
        check({tag, "_empty"}, 32'(empty), 32'(model_cnt == 0));
        check({tag, "_pulses"},
              32'({enter_pulse, exit_pulse, ovf_pulse, udf_pulse}), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        RSTN = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        RSTN = 1'b1;
        step(2'b00, 10);
        check_state("reset");

        do_entry();
        check_state("entry1");
        do_exit();
        check_state("exit1");
        do_exit();
        check_state("udf");

        // Aborts and backing out
        step(2'b10, 10);
        step(2'b00, 10);
        check_state("abort1");
        step(2'b10, 10);
        step(2'b11, 10);
        step(2'b10, 10);
        step(2'b00, 10);
        check_state("abort2");
        step(2'b10, 10);
        step(2'b11, 10);
        step(2'b01, 10);
        step(2'b11, 10);
        step(2'b10, 10);
        step(2'b00, 10);
        check_state("abort3");

        // Short glitches must not reach the FSM
        step(2'b10, 3);
        step(2'b00, 10);
        check_state("glitch_idle");
        // A 3-cycle drop to 00 while in EN3 would otherwise commit an entry
        step(2'b10, 10);
        step(2'b11, 10);
        step(2'b01, 10);
        step(2'b00, 3);
        step(2'b01, 10);
        step(2'b11, 10);
        step(2'b10, 10);
        step(2'b00, 10);
        check_state("glitch_en3");

        // Entry with 2-cycle bounces at every transition counts once
        model_cnt++;
        push_exp(EvEnter);
        step(2'b10, 2);
        step(2'b00, 2);
        step(2'b10, 10);
        step(2'b11, 2);
        step(2'b10, 2);
        step(2'b11, 10);
        step(2'b01, 2);
        step(2'b11, 2);
        step(2'b01, 10);
        step(2'b00, 2);
        step(2'b01, 2);
        step(2'b00, 10);
        check_state("bounce");

        // Fill to capacity, then overflow
        for (int i = 0; i < 24; i++) do_entry();
        check_state("fill");
        do_entry();
        check_state("ovf");

        // Drain to 7, then reset in the middle of an entry
        for (int i = 0; i < 18; i++) do_exit();
        check_state("drain");
        step(2'b10, 10);
        step(2'b11, 10);
        RSTN = 1'b0;
        #1;
        check("midrst_cnt", 32'(cntNum), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        @(posedge CLOCK_50);
        #1;
        RSTN = 1'b1;
        model_cnt = 0;
        step(2'b01, 10);
        step(2'b00, 10);
        check_state("midrst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
